shift_seq_ctrl: RTL
===================

# shift_seq_ctrl

Multi-cycle sequencer that performs a 16-bit shift or rotate by 0–15 bits using one 2-bit shift stage plus one 1-bit stage, iterated over several cycles. It sits beside the execute stage of the pipelined processor. It latches an operand on `start`, steps it through the stage each cycle while asserting `busy` to stall the pipeline, and pulses `done` with the result. This replaces a full four-level barrel shifter with one reused stage.

## Interface
- No parameters; data width fixed at 16, count width fixed at 4.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `flush`  in  1  synchronous abort of an in-flight operation
- `In`  in  16  operand, captured on accepted `start`
- `Cnt`  in  4  shift amount 0–15, captured on accepted `start`
- `Op`  in  2  operation code, captured on accepted `start`:
  - 00 rotate left
  - 01 shift left (zero fill)
  - 10 rotate right
  - 11 logical shift right (zero fill)
- `Out`  out  16  result register
- `busy`  out  1  high in SHIFT1/SHIFT2; pipeline stall request
- `done`  out  1  one-cycle pulse; `Out` is valid while high

## Operation
- Internal registers:
  - `data[15:0]`
  - `op[1:0]`
  - `rem[2:0]`: remaining 2-bit steps
  - 2-bit state: IDLE, SHIFT1, SHIFT2, DONE
- `Out` is driven directly from `data`.
- IDLE or DONE with `start`=1:
  - Load `data`←`In`, `op`←`Op`, `rem`←`Cnt[3:1]`.
  - Next state is SHIFT1 if `Cnt[0]`=1.
  - Otherwise SHIFT2 if `Cnt[3:1]`≠0.
  - Otherwise DONE (Cnt=0).
- IDLE with `start`=0: stay in IDLE. DONE with `start`=0: go to IDLE.
- SHIFT1: apply the 1-bit form of `op` to `data`. Next state is SHIFT2 if `rem`≠0, else DONE.
- SHIFT2: apply the 2-bit form of `op` to `data` and decrement `rem`. Next state is DONE when `rem`=1 before the decrement, else stay in SHIFT2.
- 1-bit forms:
  - rotl `{d[14:0],d[15]}`
  - shl `{d[14:0],1'b0}`
  - rotr `{d[0],d[15:1]}`
  - shr `{1'b0,d[15:1]}`
- 2-bit forms: identical to the existing 2-bit stage encoding (same op mapping, zero fill for shifts).
- Odd counts always do the 1-bit step first, then the 2-bit steps. The result equals a single shift by `Cnt`.
- `In`, `Cnt`, `Op` changes while busy are ignored. `start` while busy is ignored (not queued).
- `flush`=1 in any state: next state IDLE, no `done` pulse, `data` retains its current value.
- Priority: `rst` > `flush` > `start`.

## Timing
- Reset values: state IDLE, `Out`=0x0000, `busy`=0, `done`=0, `rem`=0, `op`=00.
- With `start` accepted at edge k, `done` is high in the cycle following edge k + `Cnt[0]` + `Cnt[3:1]`. In other words, edges to DONE = 1 + `Cnt[0]` + `Cnt[3:1]`.
- Example latencies: Cnt=0 gives 1 edge, Cnt=1 gives 2 edges, Cnt=15 gives 9 edges.
- `busy` is combinational from state only. It is high from the cycle after acceptance until the cycle before `done`. It is never high together with `done`.
- Back-to-back: `start` during DONE is accepted. `done` then drops next cycle and the new operation begins with no idle bubble.
- `Out` holds its last result in IDLE. It changes only during SHIFT1/SHIFT2 and on load.
- A `rst` mid-operation returns all outputs to reset values at the next edge.

## Test plan
- Reset: assert `rst` for 2 cycles during a Cnt=15 operation -> `Out`=0x0000, `busy`=0, `done`=0, state IDLE.
- `In`=0x8001, `Op`=00, `Cnt`=5 -> `busy` high 3 cycles, `done` after 4th edge, `Out`=0x0030.
- `In`=0xF000, `Op`=11, `Cnt`=4 -> `done` after 3 edges, `Out`=0x0F00; `In`=0x00FF, `Op`=01, `Cnt`=3 -> `Out`=0x07F8 after 3 edges.
- `In`=0x0001, `Op`=10, `Cnt`=15 -> `done` after 9 edges, `Out`=0x0002. Then `Cnt`=0, `In`=0x1234 issued in the DONE cycle -> `done` again next-next cycle, `Out`=0x1234, no `busy`.
- `Cnt`=12 started, `flush` on 3rd busy cycle -> state IDLE next edge, no `done` pulse. A new `start` with `In`=0x0003, `Op`=01, `Cnt`=2 -> `Out`=0x000C.
- Pulse `start` with different `In` while busy -> ignored; original result and latency are unchanged.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Multi-cycle 16-bit shift/rotate by 0-15 bits. A single 1-bit stage and a single
// 2-bit stage are reused over several cycles in place of a full barrel shifter.
// An operand is latched on an accepted start, stepped through the stages while
// busy stalls the pipeline, and done pulses for one cycle with the result.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request, honoured only in IDLE or DONE
//   flush  in   1   synchronous abort; returns to IDLE without a done pulse
//   In     in  16   operand, captured on accepted start
//   Cnt    in   4   shift amount 0-15, captured on accepted start
//   Op     in   2   00 rotl, 01 shl, 10 rotr, 11 shr (logical)
//   Out    out 16   result register
//   busy   out  1   high while shifting (SHIFT1/SHIFT2)
//   done   out  1   one-cycle pulse, Out valid while high
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT1 = 2'd1;
    localparam logic [1:0] SHIFT2 = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state, state_next;
    logic [15:0] data, data_next;
    logic [1:0]  opc, opc_next;
    logic [2:0]  rem, rem_next;     // remaining 2-bit steps
    logic [15:0] step1, step2;

    // Single-bit stage
    always_comb begin
        case (opc)
            2'b00:   step1 = {data[14:0], data[15]};
            2'b01:   step1 = {data[14:0], 1'b0};
            2'b10:   step1 = {data[0], data[15:1]};
            default: step1 = {1'b0, data[15:1]};
        endcase
    end

    // Two-bit stage, same op mapping
    always_comb begin
        case (opc)
            2'b00:   step2 = {data[13:0], data[15:14]};
            2'b01:   step2 = {data[13:0], 2'b00};
            2'b10:   step2 = {data[1:0], data[15:2]};
            default: step2 = {2'b00, data[15:2]};
        endcase
    end

    always_comb begin
        state_next = state;
        data_next  = data;
        opc_next   = opc;
        rem_next   = rem;
        if (flush) begin
            // Abort keeps data as-is so Out still shows the partial value
            state_next = IDLE;
        end else begin
            case (state)
                SHIFT1: begin
                    data_next  = step1;
                    state_next = (rem != 3'd0) ? SHIFT2 : DONE;
                end
                SHIFT2: begin
                    data_next  = step2;
                    rem_next   = rem - 3'd1;
                    state_next = (rem == 3'd1) ? DONE : SHIFT2;
                end
                default: begin // IDLE, DONE
                    if (start) begin
                        data_next = In;
                        opc_next  = Op;
                        rem_next  = Cnt[3:1];
                        // Odd counts take the 1-bit step first
                        if (Cnt[0]) begin
                            state_next = SHIFT1;
                        end else if (Cnt[3:1] != 3'd0) begin
                            state_next = SHIFT2;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data  <= 16'h0000;
            opc   <= 2'b00;
            rem   <= 3'd0;
        end else begin
            state <= state_next;
            data  <= data_next;
            opc   <= opc_next;
            rem   <= rem_next;
        end
    end

    assign Out  = data;
    assign busy = (state == SHIFT1) || (state == SHIFT2);
    assign done = (state == DONE);

endmodule
